// File: rtl/control_unit_seq.sv
// Registered decode/control stage: one cycle from acceptance to control outputs.
// Block memory transfers expand into one micro-op per selected register while upstream is held.
module control_unit_seq #(
   parameter  int NUM_REGS  = 16,
   parameter  int EXE_CMD_W = 4,
   localparam int IDX_W     = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   output logic                 ready_in,
   input  logic [1:0]           mode,
   input  logic [3:0]           op_code,
   input  logic                 S,
   input  logic                 block,
   input  logic [NUM_REGS-1:0]  reg_list,
   input  logic                 stall,
   input  logic                 flush,
   output logic                 valid_out,
   output logic [EXE_CMD_W-1:0] Execute_command,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 WB_enable,
   output logic                 B,
   output logic                 Update_SR,
   output logic [IDX_W-1:0]     xfer_reg,
   output logic [IDX_W+1:0]     xfer_offset,
   output logic                 last_beat
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   localparam logic [1:0] MODE_COMPUTE = 2'b00;
   localparam logic [1:0] MODE_MEMORY  = 2'b01;
   localparam logic [1:0] MODE_BRANCH  = 2'b10;

   localparam logic [IDX_W-1:0]    ONE_IDX  = 1;
   localparam logic [NUM_REGS-1:0] ONE_MASK = 1;

   function automatic logic [EXE_CMD_W-1:0] cmd(input logic [3:0] c);
      cmd = EXE_CMD_W'(c);
   endfunction

   // Index of the lowest set bit; scanning downward lets the lowest match win.
   function automatic logic [IDX_W-1:0] lsb_idx(input logic [NUM_REGS-1:0] m);
      lsb_idx = '0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (m[i]) lsb_idx = i[IDX_W-1:0];
      end
   endfunction

   logic [0:0]           state_q, state_d;
   logic [NUM_REGS-1:0]  mask_q, mask_d;
   logic [IDX_W-1:0]     beat_q, beat_d;
   logic                 load_q, load_d;

   logic                 vld_q, vld_d;
   logic [EXE_CMD_W-1:0] cmd_q, cmd_d;
   logic                 mr_q, mr_d;
   logic                 mw_q, mw_d;
   logic                 wb_q, wb_d;
   logic                 b_q, b_d;
   logic                 usr_q, usr_d;
   logic [IDX_W-1:0]     xr_q, xr_d;
   logic [IDX_W+1:0]     xo_q, xo_d;
   logic                 last_q, last_d;

   logic [NUM_REGS-1:0]  mask_rest;
   logic [NUM_REGS-1:0]  list_rest;
   logic                 accept;

   // x & (x-1) drops the lowest set bit: the remaining mask after one beat.
   assign mask_rest = mask_q & (mask_q - ONE_MASK);
   assign list_rest = reg_list & (reg_list - ONE_MASK);

   assign ready_in = ~flush & ~stall & (state_q == ST_IDLE);
   assign accept   = valid_in & ready_in;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      beat_d  = beat_q;
      load_d  = load_q;
      vld_d   = vld_q;
      cmd_d   = cmd_q;
      mr_d    = mr_q;
      mw_d    = mw_q;
      wb_d    = wb_q;
      b_d     = b_q;
      usr_d   = usr_q;
      xr_d    = xr_q;
      xo_d    = xo_q;
      last_d  = last_q;

      if (flush || !stall) begin
         vld_d  = 1'b0;
         cmd_d  = '0;
         mr_d   = 1'b0;
         mw_d   = 1'b0;
         wb_d   = 1'b0;
         b_d    = 1'b0;
         usr_d  = 1'b0;
         xr_d   = '0;
         xo_d   = '0;
         last_d = 1'b0;
      end

      if (flush) begin
         state_d = ST_IDLE;
         mask_d  = '0;
         beat_d  = '0;
         load_d  = 1'b0;
      end else if (!stall) begin
         if (state_q == ST_BURST) begin
            vld_d  = 1'b1;
            cmd_d  = cmd(4'b0010);
            mr_d   = load_q;
            mw_d   = ~load_q;
            wb_d   = load_q;
            xr_d   = lsb_idx(mask_q);
            xo_d   = {beat_q, 2'b00};
            mask_d = mask_rest;
            beat_d = beat_q + ONE_IDX;
            last_d = (mask_rest == '0);
            if (mask_rest == '0) state_d = ST_IDLE;
         end else if (accept) begin
            vld_d  = 1'b1;
            last_d = 1'b1;
            unique case (mode)
               MODE_COMPUTE: begin
                  wb_d  = 1'b1;
                  usr_d = S;
                  unique case (op_code)
                     4'b1101: cmd_d = cmd(4'b0001);
                     4'b1111: cmd_d = cmd(4'b1001);
                     4'b0100: cmd_d = cmd(4'b0010);
                     4'b0101: cmd_d = cmd(4'b0011);
                     4'b0010: cmd_d = cmd(4'b0100);
                     4'b0110: cmd_d = cmd(4'b0101);
                     4'b0000: cmd_d = cmd(4'b0110);
                     4'b1100: cmd_d = cmd(4'b0111);
                     4'b0001: cmd_d = cmd(4'b1000);
                     4'b1010: begin cmd_d = cmd(4'b0100); wb_d = 1'b0; usr_d = 1'b1; end
                     4'b1000: begin cmd_d = cmd(4'b0110); wb_d = 1'b0; usr_d = 1'b1; end
                     default: begin wb_d = 1'b0; usr_d = 1'b0; end
                  endcase
               end
               MODE_MEMORY: begin
                  cmd_d = cmd(4'b0010);
                  mr_d  = S;
                  mw_d  = ~S;
                  wb_d  = S;
                  if (block) begin
                     xr_d = lsb_idx(reg_list);
                     if (reg_list == '0) begin
                        // Empty list is consumed silently.
                        vld_d = 1'b0; cmd_d = '0; mr_d = 1'b0; mw_d = 1'b0;
                        wb_d = 1'b0; last_d = 1'b0;
                     end else if (list_rest != '0) begin
                        last_d  = 1'b0;
                        mask_d  = list_rest;
                        beat_d  = ONE_IDX;
                        load_d  = S;
                        state_d = ST_BURST;
                     end
                  end
               end
               MODE_BRANCH: b_d = 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         beat_q  <= '0;
         load_q  <= 1'b0;
         vld_q   <= 1'b0;
         cmd_q   <= '0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         wb_q    <= 1'b0;
         b_q     <= 1'b0;
         usr_q   <= 1'b0;
         xr_q    <= '0;
         xo_q    <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         beat_q  <= beat_d;
         load_q  <= load_d;
         vld_q   <= vld_d;
         cmd_q   <= cmd_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         wb_q    <= wb_d;
         b_q     <= b_d;
         usr_q   <= usr_d;
         xr_q    <= xr_d;
         xo_q    <= xo_d;
         last_q  <= last_d;
      end
   end

   assign valid_out       = vld_q;
   assign Execute_command = cmd_q;
   assign mem_read        = mr_q;
   assign mem_write       = mw_q;
   assign WB_enable       = wb_q;
   assign B               = b_q;
   assign Update_SR       = usr_q;
   assign xfer_reg        = xr_q;
   assign xfer_offset     = xo_q;
   assign last_beat       = last_q;

endmodule

// File: doc/control_unit_seq.md
Name: control_unit_seq

Overview:
- Registered, parametrised decode/control stage sitting between instruction decode and the ID/EX boundary.
- Translates mode/op_code/S into execute command and control strobes, one cycle after acceptance.
- Adds block memory transfers: one accepted instruction with a register list is expanded into one memory micro-op per selected register, issued on consecutive cycles, while upstream is held.
- Supports downstream stall and pipeline flush.

Parameters:
- NUM_REGS, 16, width of reg_list and number of architectural registers addressable by a block transfer.
- EXE_CMD_W, 4, width of Execute_command.
- IDX_W, $clog2(NUM_REGS), derived (localparam); width of xfer_reg.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  instruction present on decode inputs.
- ready_in  out  1  unit accepts instruction this cycle (combinational).
- mode  in  2  00 COMPUTE, 01 MEMORY, 10 BRANCH, 11 reserved.
- op_code  in  4  ALU opcode (COMPUTE mode).
- S  in  1  COMPUTE: set flags; MEMORY: 1 = load, 0 = store.
- block  in  1  MEMORY only: block transfer using reg_list.
- reg_list  in  NUM_REGS  block transfer register mask, bit i = register i.
- stall  in  1  downstream hold; registered outputs and state frozen.
- flush  in  1  discard current output and any burst in progress.
- valid_out  out  1  registered outputs carry a real micro-op.
- Execute_command  out  EXE_CMD_W  ALU command.
- mem_read, mem_write, WB_enable, B, Update_SR  out  1 each  control strobes.
- xfer_reg  out  IDX_W  destination/source register of current block beat (0 when not a block beat).
- xfer_offset  out  IDX_W+2  byte offset of current beat = beat_number*4 (0 for single transfers).
- last_beat  out  1  final (or only) micro-op of an instruction.

Behaviour:
- Reset (rst=1 at clk edge): all registered outputs 0, state IDLE, internal mask 0. ready_in=1 after reset.
- Acceptance: valid_in & ready_in & ~stall. Result appears on outputs the following cycle (latency 1).
- Decode, COMPUTE: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000; all WB_enable=1, Update_SR=S. CMP 1010->0100 and TST 1000->0110: WB_enable=0, Update_SR=1 regardless of S. Other opcodes: NOP (command 0, all strobes 0, valid_out=1).
- Decode, MEMORY: Execute_command=0010, mem_read=S, mem_write=~S, WB_enable=S, Update_SR=0.
- Decode, BRANCH: B=1, all else 0. Mode 11: NOP, valid_out=1.
- last_beat=1 for every non-block micro-op.
- FSM IDLE -> BURST: accepted MEMORY with block=1 and popcount(reg_list)>=2. Otherwise the unit stays in IDLE.
- In IDLE for block=1 with exactly one bit set: single beat with that xfer_reg, offset 0, last_beat=1.
- block=1 with reg_list=0: consumed with valid_out=0.
- Block beat order: lowest set bit first.
  - Beat k (0-based) drives xfer_reg = index of k-th set bit and xfer_offset = 4k.
  - Memory strobes are repeated on every beat.
  - The remaining mask is stored internally; the issued bit is cleared each beat.
- BURST: ready_in=0. One beat per non-stalled cycle. The beat that clears the last mask bit asserts last_beat=1 and returns to IDLE; ready_in=1 in that same cycle, so a back-to-back instruction is accepted with no bubble.
- stall=1: all registered outputs, mask and state hold; ready_in=0. flush has priority over stall.
- flush=1: next edge clears valid_out and all strobes to 0, state -> IDLE, mask cleared. Any instruction presented that cycle is not accepted (ready_in=0 while flush=1).
- rst mid-burst: identical to flush plus the reset values above.
- No accepted instruction and not in BURST: next edge loads valid_out=0 and all strobes 0.

Test Plan:
- Reset, then COMPUTE ADD S=1: one cycle later valid_out=1, Execute_command=0010, WB_enable=1, Update_SR=1, last_beat=1.
- CMP with S=0: Execute_command=0100, WB_enable=0, Update_SR=1; undefined op_code 0011: valid_out=1, all strobes 0.
- MEMORY block load (S=1), reg_list=16'h00A2, then an ADD presented immediately:
  - Three beats: xfer_reg 1/5/7, offsets 0/4/8, mem_read=1, WB_enable=1, last_beat only on the third beat.
  - ready_in low for the first two beat cycles; ADD is output the cycle after beat 3.
- Block store reg_list=16'h0003 with stall=1 held 2 cycles after beat 0: beat 0 outputs frozen for 2 cycles, then beat 1 (xfer_reg=1, offset 4, mem_write=1, last_beat=1).
- flush on beat 1 of a 4-register burst: next cycle valid_out=0, ready_in=1, no further beats; rst mid-burst gives the same result with all outputs 0.
- block=1, reg_list=0: no valid_out pulse, ready_in stays 1; BRANCH: B=1 only.
